// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 divider (single/double) using radix-2 restoring division,
// one quotient bit per cycle behind a start/busy/done handshake.
module fp_divider_iter #(
    parameter int DBL_QBITS = 55,
    parameter int SGL_QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] operand_a,
    input  logic [63:0] operand_b,
    input  logic        is_double_precision,
    input  logic [2:0]  rounding_mode,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic        flag_invalid,
    output logic        flag_div_by_zero,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [63:0] QNAN_DBL = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] QNAN_SGL = 64'h0000_0000_7FC0_0000;

    logic [2:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [63:0]        result_q, result_d;
    logic [4:0]         flags_q, flags_d;   // {invalid, div_by_zero, overflow, underflow, inexact}
    logic [63:0]        a_q, a_d, b_q, b_d;
    logic               dbl_q, dbl_d;
    logic               rne_q, rne_d;
    logic               sign_q, sign_d;
    logic [54:0]        rem_q, rem_d;
    logic [54:0]        quo_q, quo_d;
    logic [52:0]        mb_q, mb_d;
    logic signed [12:0] exp_q, exp_d;
    logic [5:0]         cnt_q, cnt_d;

    function automatic logic [5:0] lzc53(input logic [52:0] m);
        lzc53 = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (m[i]) lzc53 = 6'(52 - i);
        end
    endfunction

    function automatic logic [63:0] pack_inf(input logic dbl, input logic s);
        pack_inf = dbl ? {s, 11'h7FF, 52'd0} : {32'd0, s, 8'hFF, 23'd0};
    endfunction

    function automatic logic [63:0] pack_zero(input logic dbl, input logic s);
        pack_zero = dbl ? {s, 63'd0} : {32'd0, s, 31'd0};
    endfunction

    logic signed [12:0] bias_s;
    logic signed [12:0] emin_s;
    assign bias_s = dbl_q ? 13'sd1023 : 13'sd127;
    assign emin_s = 13'sd1 - bias_s;

    // Operand unpack; single-precision mantissas are left-aligned into 53 bits
    // so one datapath serves both formats.
    logic [63:0]        opnd      [2];
    logic               op_sign   [2];
    logic               op_nan    [2];
    logic               op_snan   [2];
    logic               op_inf    [2];
    logic               op_zero   [2];
    logic [52:0]        op_mant   [2];
    logic signed [12:0] op_exp    [2];

    assign opnd[0] = a_q;
    assign opnd[1] = b_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [10:0] efld;
            logic [51:0] frac;
            logic        e_all1, e_zero, f_nz;
            logic [52:0] raw;
            logic [5:0]  lz;

            assign efld   = dbl_q ? opnd[gi][62:52] : {3'b000, opnd[gi][30:23]};
            assign frac   = dbl_q ? opnd[gi][51:0]  : {opnd[gi][22:0], 29'd0};
            assign e_all1 = dbl_q ? (efld == 11'h7FF) : (efld == 11'h0FF);
            assign e_zero = (efld == 11'd0);
            assign f_nz   = (frac != 52'd0);
            assign raw    = {~e_zero, frac};
            assign lz     = lzc53(raw);

            assign op_sign[gi] = dbl_q ? opnd[gi][63] : opnd[gi][31];
            assign op_nan[gi]  = e_all1 & f_nz;
            assign op_snan[gi] = e_all1 & f_nz & ~frac[51];
            assign op_inf[gi]  = e_all1 & ~f_nz;
            assign op_zero[gi] = e_zero & ~f_nz;
            assign op_mant[gi] = raw << lz;
            assign op_exp[gi]  = e_zero ? (emin_s - $signed({7'd0, lz}))
                                        : ($signed({2'b00, efld}) - bias_s);
        end
    endgenerate

    // Special-case resolution, evaluated while in PREP.
    logic        res_sign;
    logic        spec_hit;
    logic [63:0] spec_res;
    logic [4:0]  spec_flags;

    assign res_sign = op_sign[0] ^ op_sign[1];

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = 64'd0;
        spec_flags = 5'd0;
        if (op_nan[0] || op_nan[1]) begin
            spec_res   = dbl_q ? QNAN_DBL : QNAN_SGL;
            spec_flags = {op_snan[0] | op_snan[1], 4'd0};
        end else if ((op_zero[0] && op_zero[1]) || (op_inf[0] && op_inf[1])) begin
            spec_res   = dbl_q ? QNAN_DBL : QNAN_SGL;
            spec_flags = 5'b10000;
        end else if (op_zero[1] && !op_inf[0]) begin
            spec_res   = pack_inf(dbl_q, res_sign);
            spec_flags = 5'b01000;
        end else if (op_inf[0]) begin
            spec_res   = pack_inf(dbl_q, res_sign);
        end else if (op_inf[1] || op_zero[0]) begin
            spec_res   = pack_zero(dbl_q, res_sign);
        end else begin
            spec_hit   = 1'b0;
        end
    end

    // Pre-scale the dividend so the quotient lands in [1,2).
    logic               a_lt;
    logic [54:0]        rem_init;
    logic signed [12:0] exp_init;

    assign a_lt     = op_mant[0] < op_mant[1];
    assign rem_init = a_lt ? {1'b0, op_mant[0], 1'b0} : {2'b00, op_mant[0]};
    assign exp_init = op_exp[0] - op_exp[1] - (a_lt ? 13'sd1 : 13'sd0);

    logic        div_ge;
    logic [54:0] rem_sub;
    logic [5:0]  last_cnt;

    assign div_ge   = rem_q >= {2'b00, mb_q};
    assign rem_sub  = div_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    assign last_cnt = dbl_q ? 6'(DBL_QBITS - 1) : 6'(SGL_QBITS - 1);

    // Rounding, overflow and gradual underflow on the finished quotient.
    logic signed [12:0] emax, sh, sh_lim, exp_fin;
    logic               uf, tiny, ovf;
    logic [5:0]         sh6;
    logic [54:0]        qs;
    logic               lost, g0, r0, s0, g, r, s, inc, carry;
    logic [52:0]        mpre;
    logic [53:0]        mrnd;
    logic [10:0]        biased;
    logic [63:0]        rnd_res;
    logic [4:0]         rnd_flags;

    always_comb begin
        emax    = bias_s;
        uf      = exp_q < emin_s;
        sh      = emin_s - exp_q;
        sh_lim  = dbl_q ? 13'sd54 : 13'sd24;
        tiny    = uf && (sh >= sh_lim);
        sh6     = sh[5:0];
        g0      = quo_q[1];
        r0      = quo_q[0];
        s0      = |rem_q;
        qs      = quo_q;
        lost    = 1'b0;
        if (uf) begin
            qs   = quo_q >> sh6;
            lost = |(quo_q & ((55'd1 << sh6) - 55'd1));
        end
        g       = qs[1];
        r       = qs[0];
        s       = s0 | lost;
        mpre    = qs[54:2];
        inc     = rne_q & g & (r | s | mpre[0]);
        mrnd    = {1'b0, mpre} + {53'd0, inc};
        carry   = dbl_q ? mrnd[53] : mrnd[24];
        exp_fin = exp_q + $signed({12'd0, carry});
        ovf     = !uf && (exp_fin > emax);
        biased  = exp_fin[10:0] + (dbl_q ? 11'd1023 : 11'd127);

        if (tiny) begin
            rnd_res   = pack_zero(dbl_q, sign_q);
            rnd_flags = 5'b00011;
        end else if (uf) begin
            rnd_res   = dbl_q ? {sign_q, 10'd0, mrnd[52], mrnd[51:0]}
                              : {32'd0, sign_q, 7'd0, mrnd[23], mrnd[22:0]};
            rnd_flags = {4'b0001, g0 | r0 | s0 | g | r | s};
        end else if (ovf) begin
            rnd_res   = pack_inf(dbl_q, sign_q);
            rnd_flags = 5'b00101;
        end else begin
            rnd_res   = dbl_q ? {sign_q, biased, mrnd[51:0]}
                              : {32'd0, sign_q, biased[7:0], mrnd[22:0]};
            rnd_flags = {4'b0000, g | r | s};
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        a_d      = a_q;
        b_d      = b_q;
        dbl_d    = dbl_q;
        rne_d    = rne_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_PREP;
                    busy_d   = 1'b1;
                    a_d      = operand_a;
                    b_d      = operand_b;
                    dbl_d    = is_double_precision;
                    rne_d    = (rounding_mode == 3'b000);
                    result_d = 64'd0;
                    flags_d  = 5'd0;
                end
            end
            S_PREP: begin
                sign_d = res_sign;
                if (spec_hit) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = spec_res;
                    flags_d  = spec_flags;
                end else begin
                    state_d = S_DIV;
                    rem_d   = rem_init;
                    mb_d    = op_mant[1];
                    exp_d   = exp_init;
                    quo_d   = 55'd0;
                    cnt_d   = 6'd0;
                end
            end
            S_DIV: begin
                rem_d = {rem_sub[53:0], 1'b0};
                quo_d = {quo_q[53:0], div_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == last_cnt) state_d = S_ROUND;
            end
            S_ROUND: begin
                state_d  = S_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = rnd_res;
                flags_d  = rnd_flags;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
            flags_q  <= 5'd0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            dbl_q    <= 1'b0;
            rne_q    <= 1'b0;
            sign_q   <= 1'b0;
            rem_q    <= 55'd0;
            quo_q    <= 55'd0;
            mb_q     <= 53'd0;
            exp_q    <= 13'sd0;
            cnt_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dbl_q    <= dbl_d;
            rne_q    <= rne_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;
    assign flag_invalid     = flags_q[4];
    assign flag_div_by_zero = flags_q[3];
    assign flag_overflow    = flags_q[2];
    assign flag_underflow   = flags_q[1];
    assign flag_inexact     = flags_q[0];

endmodule

// File: tb/tb_fp_divider_iter.sv
// Scoreboard bench for fp_divider_iter: directed vectors push expectations,
// a monitor pops and compares on every done pulse.
module tb_fp_divider_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] operand_a, operand_b;
    logic        is_double_precision;
    logic [2:0]  rounding_mode;
    logic        busy, done;
    logic [63:0] result;
    logic        flag_invalid, flag_div_by_zero, flag_overflow, flag_underflow, flag_inexact;

    always #5 clk = ~clk;

    fp_divider_iter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .operand_a           (operand_a),
        .operand_b           (operand_b),
        .is_double_precision (is_double_precision),
        .rounding_mode       (rounding_mode),
        .busy                (busy),
        .done                (done),
        .result              (result),
        .flag_invalid        (flag_invalid),
        .flag_div_by_zero    (flag_div_by_zero),
        .flag_overflow       (flag_overflow),
        .flag_underflow      (flag_underflow),
        .flag_inexact        (flag_inexact)
    );

    typedef struct {
        string       nm;
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] flags_now();
        return {flag_invalid, flag_div_by_zero, flag_overflow, flag_underflow, flag_inexact};
    endfunction

    function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endfunction

    // Monitor: compares the oldest expectation on each done pulse.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual done=1 required no done (cycle %0d)", cyc);
                end else begin
                    e   = sb_q.pop_front();
                    lat = cyc - e.t0 + 1;
                    $display("txn %-14s result=%h flags=%b latency=%0d", e.nm, result, flags_now(), lat);
                    check({e.nm, "_result"},  result,            e.res);
                    check({e.nm, "_flags"},   64'(flags_now()),  64'(e.flg));
                    check({e.nm, "_latency"}, 64'(lat),          64'(e.lat));
                    check({e.nm, "_busy"},    64'(busy),         64'd0);
                end
            end
        end
    end

    task automatic issue(string nm, logic [63:0] a, logic [63:0] b, logic dbl, logic [2:0] rm,
                         logic [63:0] res, logic [4:0] flg, int lat, bit expect_done);
        exp_t e;
        @(negedge clk);
        operand_a           = a;
        operand_b           = b;
        is_double_precision = dbl;
        rounding_mode       = rm;
        start               = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) begin
            e.nm  = nm;
            e.res = res;
            e.flg = flg;
            e.lat = lat;
            e.t0  = cyc;
            sb_q.push_back(e);
        end
        check({nm, "_busy_accept"},  64'(busy), 64'd1);
        check({nm, "_result_clear"}, result,    64'd0);
        @(negedge clk);
        start     = 1'b0;
        operand_a = 64'hDEAD_BEEF_DEAD_BEEF;
        operand_b = 64'h0123_4567_89AB_CDEF;
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual pending=%0d required 0 after 200 cycles", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run(string nm, logic [63:0] a, logic [63:0] b, logic dbl, logic [2:0] rm,
                       logic [63:0] res, logic [4:0] flg, int lat);
        issue(nm, a, b, dbl, rm, res, flg, lat, 1'b1);
        wait_idle(nm);
    endtask

    initial begin
        rst_n               = 1'b0;
        start               = 1'b0;
        operand_a           = 64'd0;
        operand_b           = 64'd0;
        is_double_precision = 1'b0;
        rounding_mode       = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   64'(busy),        64'd0);
        check("reset_done",   64'(done),        64'd0);
        check("reset_result", result,           64'd0);
        check("reset_flags",  64'(flags_now()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // name, a, b, dbl, rm, result, {inv,dbz,ovf,uf,inx}, latency
        run("d_6div2",     64'h4018000000000000, 64'h4000000000000000, 1, 3'b000, 64'h4008000000000000, 5'b00000, 58);
        repeat (3) @(negedge clk);
        check("result_hold", result, 64'h4008000000000000);
        run("s_1div3_rne", 64'h3F800000, 64'h40400000, 0, 3'b000, 64'h3EAAAAAB, 5'b00001, 29);
        run("s_1div3_trc", 64'h3F800000, 64'h40400000, 0, 3'b001, 64'h3EAAAAAA, 5'b00001, 29);
        run("s_m1div3",    64'hBF800000, 64'h40400000, 0, 3'b000, 64'hBEAAAAAB, 5'b00001, 29);
        run("d_1div3",     64'h3FF0000000000000, 64'h4008000000000000, 1, 3'b000, 64'h3FD5555555555555, 5'b00001, 58);
        run("d_1div0",     64'h3FF0000000000000, 64'h0000000000000000, 1, 3'b000, 64'h7FF0000000000000, 5'b01000, 2);
        run("s_1div0",     64'h3F800000, 64'h00000000, 0, 3'b000, 64'h7F800000, 5'b01000, 2);
        run("d_0div0",     64'h0000000000000000, 64'h0000000000000000, 1, 3'b000, 64'h7FF8000000000000, 5'b10000, 2);
        run("d_snan",      64'h7FF0000000000001, 64'h3FF0000000000000, 1, 3'b000, 64'h7FF8000000000000, 5'b10000, 2);
        run("d_qnan",      64'h7FF8000000000000, 64'h3FF0000000000000, 1, 3'b000, 64'h7FF8000000000000, 5'b00000, 2);
        run("s_infdivinf", 64'h7F800000, 64'h7F800000, 0, 3'b000, 64'h7FC00000, 5'b10000, 2);
        run("d_minfdiv2",  64'hFFF0000000000000, 64'h4000000000000000, 1, 3'b000, 64'hFFF0000000000000, 5'b00000, 2);
        run("d_m1divinf",  64'hBFF0000000000000, 64'h7FF0000000000000, 1, 3'b000, 64'h8000000000000000, 5'b00000, 2);
        run("d_overflow",  64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 1, 3'b000, 64'h7FF0000000000000, 5'b00101, 58);
        run("s_uf_exact",  64'h00800000, 64'h40000000, 0, 3'b000, 64'h00400000, 5'b00011 & 5'b00010, 29);
        run("s_uf_zero",   64'h00000001, 64'h40800000, 0, 3'b000, 64'h00000000, 5'b00011, 29);
        run("s_uf_carry",  64'h00FFFFFF, 64'h40000000, 0, 3'b000, 64'h00800000, 5'b00011, 29);
        run("s_uf_trunc",  64'h00FFFFFF, 64'h40000000, 0, 3'b001, 64'h007FFFFF, 5'b00011, 29);
        run("d_denorm_eq", 64'h0000000000000001, 64'h0000000000000001, 1, 3'b000, 64'h3FF0000000000000, 5'b00000, 58);
        run("d_uf_tie",    64'h0000000000000001, 64'h4000000000000000, 1, 3'b000, 64'h0000000000000000, 5'b00011, 58);

        // A second start while busy must be ignored and not queued.
        issue("d_restart", 64'h4018000000000000, 64'h4000000000000000, 1, 3'b000,
              64'h4008000000000000, 5'b00000, 58, 1'b1);
        repeat (8) @(negedge clk);
        operand_a = 64'd0;
        operand_b = 64'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        wait_idle("d_restart");
        repeat (70) @(negedge clk);

        // Reset mid-divide discards the operation with no done.
        issue("d_abort", 64'h3FF0000000000000, 64'h4008000000000000, 1, 3'b000,
              64'd0, 5'd0, 0, 1'b0);
        repeat (18) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy",   64'(busy),        64'd0);
        check("abort_done",   64'(done),        64'd0);
        check("abort_result", result,           64'd0);
        check("abort_flags",  64'(flags_now()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);

        run("d_after_rst", 64'h4018000000000000, 64'h4000000000000000, 1, 3'b000, 64'h4008000000000000, 5'b00000, 58);
        run("s_after_rst", 64'h3F800000, 64'h40400000, 0, 3'b000, 64'h3EAAAAAB, 5'b00001, 29);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
